lpif_phy_responder: RTL and testbench

LPIF_PHY_RESPONDER -- requirements
Module: lpif_phy_responder

---
 rtl/lpif_pkg.sv | 27 ++
 rtl/lpif_tx_fifo.sv | 50 +++++
 rtl/lpif_phy_responder.sv | 96 +++++++++
 tb/tb_lpif_phy_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_pkg.sv
// lpif_pkg: shared LPIF encodings, responder FSM states and transmit FIFO depth.
//   REQ_*        : lp_state_req encodings from the link layer
//   STS_*        : pl_state_sts encodings reported to the link layer
//   lpif_state_t : internal FSM states (STALL is reported as ACTIVE)
//   sts_code     : maps an FSM state to its reported status code
package lpif_pkg;
   localparam int FIFO_DEPTH = 4;
   localparam logic [3:0] REQ_NOP       = 4'b0000;
   localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
   localparam logic [3:0] REQ_L1        = 4'b0100;
   localparam logic [3:0] REQ_LINKRESET = 4'b1001;
   localparam logic [3:0] REQ_RETRAIN   = 4'b1011;
   localparam logic [3:0] STS_RESET     = 4'b0000;
   localparam logic [3:0] STS_ACTIVE    = 4'b0001;
   localparam logic [3:0] STS_L1        = 4'b0100;
   localparam logic [3:0] STS_LINKRESET = 4'b1001;
   localparam logic [3:0] STS_RETRAIN   = 4'b1011;
   typedef enum logic [2:0] {
      ST_RESET, ST_ACTIVE, ST_STALL, ST_L1, ST_LINKRESET, ST_RETRAIN
   } lpif_state_t;
   function automatic logic [3:0] sts_code(lpif_state_t s);
      return (s == ST_ACTIVE || s == ST_STALL) ? STS_ACTIVE :
             (s == ST_L1)                      ? STS_L1 :
             (s == ST_LINKRESET)               ? STS_LINKRESET :
             (s == ST_RETRAIN)                 ? STS_RETRAIN : STS_RESET;
   endfunction
endpackage

// File: rtl/lpif_tx_fifo.sv
// lpif_tx_fifo: FIFO_DEPTH-entry transmit FIFO, no bypass (1-cycle write-to-head latency).
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   flush      : synchronous empty, wins over a same-cycle write/read
//   wr, wdata  : write strobe and entry; ignored while full
//   rd         : consume the head; ignored while empty
//   rdata      : head entry, stable until consumed
//   empty, full: occupancy flags
module lpif_tx_fifo
   import lpif_pkg::*;
#(
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         wr,
   input  logic [W-1:0] wdata,
   input  logic         rd,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         full
);
   logic [W-1:0] mem [FIFO_DEPTH];
   logic [1:0]   wp, rp;
   logic [2:0]   cnt;
   logic         do_wr, do_rd;
   assign empty = cnt == 3'd0;
   assign full  = cnt == 3'(FIFO_DEPTH);
   assign do_wr = wr && !full;
   assign do_rd = rd && !empty;
   assign rdata = mem[rp];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_wr) wp <= wp + 2'd1;
         if (do_rd) rp <= rp + 2'd1;
         cnt <= cnt + 3'(do_wr) - 3'(do_rd);
      end
   end
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem[wp] <= wdata;
   end
endmodule

// File: rtl/lpif_phy_responder.sv
// lpif_phy_responder: PHY-side LPIF responder with state handshake and a 4-entry transmit FIFO.
//   PCLK, reset        : clock, asynchronous active-low reset
//   lp_irdy/lp_data/lp_valid, pl_trdy : link-layer transmit handshake
//   lp_state_req, pl_state_sts        : state request / reported state
//   pl_stall_req, lp_stall_ack        : stall handshake before leaving ACTIVE
//   pl_link_up, pl_phyinl1            : ACTIVE / L1 indications
//   pl_protocol_valid, pl_protocol    : negotiated protocol (always PCIe)
//   phy_link_trained, phy_retrain     : LTSSM status from the physical layer
//   phy_tx_data/phy_tx_valid/phy_tx_vld, phy_tx_rdy : FIFO head toward the PHY
module lpif_phy_responder
   import lpif_pkg::*;
(
   input  logic        PCLK,
   input  logic        reset,
   input  logic        lp_irdy,
   input  logic [63:0] lp_data,
   input  logic [7:0]  lp_valid,
   input  logic [3:0]  lp_state_req,
   input  logic        lp_stall_ack,
   output logic        pl_trdy,
   output logic [3:0]  pl_state_sts,
   output logic        pl_stall_req,
   output logic        pl_link_up,
   output logic        pl_phyinl1,
   output logic        pl_protocol_valid,
   output logic [2:0]  pl_protocol,
   input  logic        phy_link_trained,
   input  logic        phy_retrain,
   output logic [63:0] phy_tx_data,
   output logic [7:0]  phy_tx_valid,
   output logic        phy_tx_vld,
   input  logic        phy_tx_rdy
);
   lpif_state_t state, nxt, target;
   logic        ret_armed, link_lost, retrain_req, empty, full, wr;
   // losing training in an operational state drops to RESET and flushes queued beats
   assign link_lost   = !phy_link_trained &&
                        (state == ST_ACTIVE || state == ST_STALL || state == ST_L1);
   assign retrain_req = phy_retrain || lp_state_req == REQ_RETRAIN;
   assign pl_trdy     = state == ST_ACTIVE && !pl_stall_req && !full;
   // all-zero byte masks are handshaken but never stored
   assign wr          = lp_irdy && pl_trdy && lp_valid != 8'h00;
   assign pl_protocol = 3'b000;
   assign phy_tx_vld  = !empty;
   lpif_tx_fifo #(.W(72)) u_fifo (
      .clk   (PCLK),
      .rst_n (reset),
      .flush (link_lost),
      .wr    (wr),
      .wdata ({lp_valid, lp_data}),
      .rd    (phy_tx_rdy),
      .rdata ({phy_tx_valid, phy_tx_data}),
      .empty (empty),
      .full  (full)
   );
   always_comb begin
      nxt = state;
      if (link_lost) nxt = ST_RESET;
      else
         case (state)
            ST_RESET:     nxt = (phy_link_trained && lp_state_req == REQ_ACTIVE) ? ST_ACTIVE : state;
            ST_ACTIVE:    nxt = retrain_req ? ST_RETRAIN :
                                (lp_state_req == REQ_L1 || lp_state_req == REQ_LINKRESET) ? ST_STALL : state;
            ST_STALL:     nxt = retrain_req ? ST_RETRAIN : (lp_stall_ack && empty) ? target : state;
            ST_L1:        nxt = (lp_state_req == REQ_ACTIVE) ? ST_RETRAIN : state;
            ST_LINKRESET: nxt = (lp_state_req != REQ_LINKRESET) ? ST_RESET : state;
            ST_RETRAIN:   nxt = (ret_armed && phy_link_trained) ? ST_ACTIVE : state;
            default:      nxt = ST_RESET;
         endcase
   end
   // outputs are registered from the next state so they change together with pl_state_sts
   always_ff @(posedge PCLK or negedge reset) begin
      if (!reset) begin
         state             <= ST_RESET;
         target            <= ST_L1;
         ret_armed         <= 1'b0;
         pl_state_sts      <= STS_RESET;
         pl_stall_req      <= 1'b0;
         pl_link_up        <= 1'b0;
         pl_phyinl1        <= 1'b0;
         pl_protocol_valid <= 1'b0;
      end else begin
         state <= nxt;
         if (state == ST_ACTIVE && nxt == ST_STALL)
            target <= (lp_state_req == REQ_L1) ? ST_L1 : ST_LINKRESET;
         // a trained indication in the first RETRAIN cycle is stale and ignored
         ret_armed         <= state == ST_RETRAIN;
         pl_state_sts      <= sts_code(nxt);
         pl_stall_req      <= nxt == ST_STALL;
         pl_link_up        <= nxt == ST_ACTIVE || nxt == ST_STALL;
         pl_phyinl1        <= nxt == ST_L1;
         pl_protocol_valid <= (nxt == ST_RESET) ? 1'b0 :
                              (state == ST_RESET && nxt == ST_ACTIVE) ? 1'b1 : pl_protocol_valid;
      end
   end
endmodule

// File: tb/tb_lpif_phy_responder.sv
// tb_lpif_phy_responder: directed self-checking bench for lpif_phy_responder.
module tb_lpif_phy_responder;
   logic        PCLK = 1'b0;
   logic        reset;
   logic        lp_irdy;
   logic [63:0] lp_data;
   logic [7:0]  lp_valid;
   logic [3:0]  lp_state_req;
   logic        lp_stall_ack;
   logic        pl_trdy;
   logic [3:0]  pl_state_sts;
   logic        pl_stall_req;
   logic        pl_link_up;
   logic        pl_phyinl1;
   logic        pl_protocol_valid;
   logic [2:0]  pl_protocol;
   logic        phy_link_trained;
   logic        phy_retrain;
   logic [63:0] phy_tx_data;
   logic [7:0]  phy_tx_valid;
   logic        phy_tx_vld;
   logic        phy_tx_rdy;
   int          n_asrt = 0;
   int          n_fail = 0;
   int          in_i, out_i;
   always #5 PCLK = ~PCLK;
   lpif_phy_responder dut (
      .PCLK              (PCLK),
      .reset             (reset),
      .lp_irdy           (lp_irdy),
      .lp_data           (lp_data),
      .lp_valid          (lp_valid),
      .lp_state_req      (lp_state_req),
      .lp_stall_ack      (lp_stall_ack),
      .pl_trdy           (pl_trdy),
      .pl_state_sts      (pl_state_sts),
      .pl_stall_req      (pl_stall_req),
      .pl_link_up        (pl_link_up),
      .pl_phyinl1        (pl_phyinl1),
      .pl_protocol_valid (pl_protocol_valid),
      .pl_protocol       (pl_protocol),
      .phy_link_trained  (phy_link_trained),
      .phy_retrain       (phy_retrain),
      .phy_tx_data       (phy_tx_data),
      .phy_tx_valid      (phy_tx_valid),
      .phy_tx_vld        (phy_tx_vld),
      .phy_tx_rdy        (phy_tx_rdy)
   );
   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge PCLK);
      #1;
   endtask
   function automatic logic [71:0] beat(input int k);
      return {8'(8'hFF >> k), 32'hC0DE0000 + 32'(k), 32'h12345678 ^ 32'(k)};
   endfunction
   task automatic chk_reset_outputs(input string tag);
      chk({tag, " sts"},      72'(pl_state_sts),      72'h0);
      chk({tag, " trdy"},     72'(pl_trdy),           72'h0);
      chk({tag, " stall"},    72'(pl_stall_req),      72'h0);
      chk({tag, " link_up"},  72'(pl_link_up),        72'h0);
      chk({tag, " phyinl1"},  72'(pl_phyinl1),        72'h0);
      chk({tag, " pvalid"},   72'(pl_protocol_valid), 72'h0);
      chk({tag, " protocol"}, 72'(pl_protocol),       72'h0);
      chk({tag, " tx_vld"},   72'(phy_tx_vld),        72'h0);
   endtask
   initial begin
      reset = 1'b0; lp_irdy = 1'b0; lp_data = '0; lp_valid = '0; lp_state_req = 4'h0;
      lp_stall_ack = 1'b0; phy_link_trained = 1'b0; phy_retrain = 1'b0; phy_tx_rdy = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b1;
      step();
      chk("untrained sts", 72'(pl_state_sts), 72'h0);
      // bring-up
      phy_link_trained = 1'b1; lp_state_req = 4'b0001;
      step();
      lp_state_req = 4'b0000;
      chk("up sts",     72'(pl_state_sts),      72'h1);
      chk("up link_up", 72'(pl_link_up),        72'h1);
      chk("up pvalid",  72'(pl_protocol_valid), 72'h1);
      chk("up trdy",    72'(pl_trdy),           72'h1);
      // zero-mask beat is accepted but dropped
      phy_tx_rdy = 1'b1; lp_irdy = 1'b1; lp_valid = 8'h00; lp_data = 64'hDEAD;
      chk("zero trdy", 72'(pl_trdy), 72'h1);
      step();
      lp_irdy = 1'b0;
      chk("zero dropped", 72'(phy_tx_vld), 72'h0);
      // one-cycle latency, no bypass
      phy_tx_rdy = 1'b0; lp_irdy = 1'b1; lp_valid = 8'h0F; lp_data = 64'h1111_2222_3333_4444;
      chk("lat before", 72'(phy_tx_vld), 72'h0);
      step();
      lp_irdy = 1'b0;
      chk("lat vld",  72'(phy_tx_vld), 72'h1);
      chk("lat head", {phy_tx_valid, phy_tx_data}, 72'h0F_1111_2222_3333_4444);
      phy_tx_rdy = 1'b1;
      step();
      chk("lat drained", 72'(phy_tx_vld), 72'h0);
      // backpressure: 6 beats offered with the PHY stalled
      phy_tx_rdy = 1'b0; in_i = 0; out_i = 0;
      for (int c = 0; c < 6; c++) begin
         lp_irdy = in_i < 6;
         {lp_valid, lp_data} = beat(in_i);
         if (lp_irdy && pl_trdy) in_i++;
         step();
      end
      chk("bp accepted", 72'(in_i),       72'd4);
      chk("bp trdy",     72'(pl_trdy),    72'h0);
      chk("bp head",     {phy_tx_valid, phy_tx_data}, beat(0));
      phy_tx_rdy = 1'b1;
      for (int c = 0; c < 30 && out_i < 6; c++) begin
         lp_irdy = in_i < 6;
         {lp_valid, lp_data} = beat(in_i);
         if (phy_tx_vld) begin
            chk("bp out", {phy_tx_valid, phy_tx_data}, beat(out_i));
            out_i++;
         end
         if (lp_irdy && pl_trdy) in_i++;
         step();
      end
      lp_irdy = 1'b0;
      chk("bp all out", 72'(out_i), 72'd6);
      // L1 entry with two beats queued
      phy_tx_rdy = 1'b0; lp_irdy = 1'b1;
      {lp_valid, lp_data} = beat(0);
      step();
      {lp_valid, lp_data} = beat(1);
      step();
      lp_irdy = 1'b0;
      chk("l1 queued", 72'(phy_tx_vld), 72'h1);
      lp_state_req = 4'b0100;
      step();
      lp_state_req = 4'b0000;
      chk("l1 stall",     72'(pl_stall_req), 72'h1);
      chk("l1 stall sts", 72'(pl_state_sts), 72'h1);
      chk("l1 trdy",      72'(pl_trdy),      72'h0);
      lp_stall_ack = 1'b1;
      step();
      chk("l1 hold stall", 72'(pl_stall_req), 72'h1);
      chk("l1 hold sts",   72'(pl_state_sts), 72'h1);
      phy_tx_rdy = 1'b1;
      step();
      step();
      chk("l1 drained", 72'(phy_tx_vld),   72'h0);
      chk("l1 not yet", 72'(pl_state_sts), 72'h1);
      step();
      lp_stall_ack = 1'b0; phy_tx_rdy = 1'b0;
      chk("l1 sts",     72'(pl_state_sts), 72'h4);
      chk("l1 phyinl1", 72'(pl_phyinl1),   72'h1);
      chk("l1 stall 0", 72'(pl_stall_req), 72'h0);
      chk("l1 link_up", 72'(pl_link_up),   72'h0);
      // L1 exit through RETRAIN
      lp_state_req = 4'b0001;
      step();
      phy_link_trained = 1'b0; lp_state_req = 4'b0000;
      chk("l1x sts",     72'(pl_state_sts), 72'hB);
      chk("l1x phyinl1", 72'(pl_phyinl1),   72'h0);
      step();
      chk("l1x wait1", 72'(pl_state_sts), 72'hB);
      step();
      chk("l1x wait2", 72'(pl_state_sts), 72'hB);
      phy_link_trained = 1'b1;
      step();
      chk("l1x active",  72'(pl_state_sts), 72'h1);
      chk("l1x link_up", 72'(pl_link_up),   72'h1);
      // retrain pre-empts a stall and keeps the FIFO
      lp_irdy = 1'b1;
      {lp_valid, lp_data} = beat(2);
      step();
      lp_irdy = 1'b0; lp_state_req = 4'b1001;
      step();
      lp_state_req = 4'b0000;
      chk("rt stall", 72'(pl_stall_req), 72'h1);
      phy_retrain = 1'b1;
      step();
      phy_retrain = 1'b0;
      chk("rt stall 0", 72'(pl_stall_req), 72'h0);
      chk("rt sts",     72'(pl_state_sts), 72'hB);
      chk("rt kept",    72'(phy_tx_vld),   72'h1);
      step();
      chk("rt first cycle", 72'(pl_state_sts), 72'hB);
      step();
      chk("rt back", 72'(pl_state_sts), 72'h1);
      // link loss with three beats queued
      lp_irdy = 1'b1;
      {lp_valid, lp_data} = beat(3);
      step();
      {lp_valid, lp_data} = beat(4);
      step();
      lp_irdy = 1'b0;
      chk("ll head", {phy_tx_valid, phy_tx_data}, beat(2));
      phy_link_trained = 1'b0;
      step();
      chk("ll sts",     72'(pl_state_sts),      72'h0);
      chk("ll tx_vld",  72'(phy_tx_vld),        72'h0);
      chk("ll pvalid",  72'(pl_protocol_valid), 72'h0);
      chk("ll link_up", 72'(pl_link_up),        72'h0);
      // unlisted request ignored, then LINKRESET round trip
      phy_link_trained = 1'b1; lp_state_req = 4'b0001;
      step();
      chk("lr up", 72'(pl_state_sts), 72'h1);
      lp_state_req = 4'b0010;
      step();
      chk("odd req sts",   72'(pl_state_sts), 72'h1);
      chk("odd req stall", 72'(pl_stall_req), 72'h0);
      lp_state_req = 4'b1001; lp_stall_ack = 1'b1;
      step();
      chk("lr stall", 72'(pl_stall_req), 72'h1);
      step();
      chk("lr sts",   72'(pl_state_sts), 72'h9);
      chk("lr stall0", 72'(pl_stall_req), 72'h0);
      step();
      chk("lr hold", 72'(pl_state_sts), 72'h9);
      lp_state_req = 4'b0000; lp_stall_ack = 1'b0;
      step();
      chk("lr reset sts", 72'(pl_state_sts),      72'h0);
      chk("lr pvalid",    72'(pl_protocol_valid), 72'h0);
      // asynchronous reset with beats queued
      lp_state_req = 4'b0001;
      step();
      lp_state_req = 4'b0000; lp_irdy = 1'b1;
      {lp_valid, lp_data} = beat(0);
      step();
      {lp_valid, lp_data} = beat(1);
      step();
      lp_irdy = 1'b0;
      chk("mr queued", 72'(phy_tx_vld), 72'h1);
      #3 reset = 1'b0;
      #1;
      chk_reset_outputs("async reset");
      reset = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
